regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port between NREQ writeback sources
//   (ALU, load unit, CSR unit). Sources use a valid/ready handshake. Grants are

---
 rtl/regfile_wb_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Writeback bundle between NREQ write sources plus decode and the register-file write-port arbiter.
// The master side drives requests, reservations and queries; the slave side returns grants, the write port and busy flags.
`timescale 1ns/1ps
interface regfile_wb_if #(
    parameter int XLEN = 32,
    parameter int NREQ = 3,
    parameter int AW   = 5
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic                 rsv_valid;
    logic [AW-1:0]        rsv_addr;
    logic [AW-1:0]        rs1_addr;
    logic [AW-1:0]        rs2_addr;
    logic                 rs1_busy;
    logic                 rs2_busy;

    modport master (
        output req_valid, req_addr, req_data, rsv_valid, rsv_addr, rs1_addr, rs2_addr,
        input  req_ready, rf_we, rf_waddr, rf_wdata, rs1_busy, rs2_busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, rsv_valid, rsv_addr, rs1_addr, rs2_addr,
        output req_ready, rf_we, rf_waddr, rf_wdata, rs1_busy, rs2_busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback sources,
// with a pending-write scoreboard that lets decode stall on registers not yet written back.
`timescale 1ns/1ps
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 3,
    parameter int AW   = 5
) (
    input logic         clk,
    input logic         rst_n,
    regfile_wb_if.slave bus
);
    localparam int PW   = (NREQ > 2) ? 2 : 1;
    localparam int NREG = 1 << AW;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW:0]     cand;
    logic [NREQ-1:0] grant_oh;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        // Walk ptr+1, ptr+2, ... wrapping at NREQ; the first valid requester wins.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (PW+1)'(ptr_q) + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
            if (!grant_found && bus.req_valid[cand[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        win_addr = '0;
        win_data = '0;
        if (grant_found && rst_n) grant_oh[grant_idx] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == PW'(i)) begin
                win_addr = bus.req_addr[i*AW +: AW];
                win_data = bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_found) begin
            ptr_d      = grant_idx;
            rf_we_d    = (win_addr != '0);
            rf_waddr_d = win_addr;
            rf_wdata_d = win_data;
        end
    end

    // Clear on the commit edge first so a same-edge reservation of that register wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
        if (bus.rsv_valid && (bus.rsv_addr != '0)) busy_d[bus.rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= PW'(NREQ - 1);
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.rs1_busy  = busy_q[bus.rs1_addr];
    assign bus.rs2_busy  = busy_q[bus.rs2_addr];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants checked each cycle, write-port results
// predicted into a queue at grant time and popped one cycle later.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;
    localparam int NREQ = 3;
    localparam int AW   = 5;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    wr_t  sb[$];

    regfile_wb_if #(.XLEN(XLEN), .NREQ(NREQ), .AW(AW)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.req_addr[i*AW +: AW]     = a;
        bus.req_data[i*XLEN +: XLEN] = d;
    endtask

    // Check the grant for the current inputs, predict the write, cross the edge, compare the port.
    task automatic cycle(input logic [NREQ-1:0] exp_ready, input string tag);
        wr_t e;
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
        for (int i = 0; i < NREQ; i++) begin
            if (exp_ready[i]) begin
                e.addr = bus.req_addr[i*AW +: AW];
                e.data = bus.req_data[i*XLEN +: XLEN];
                e.we   = (e.addr != '0);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_we"},    32'(bus.rf_we),    32'(e.we));
            chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(e.addr));
            chk({tag, "_wdata"}, bus.rf_wdata,      e.data);
        end else begin
            chk({tag, "_we_idle"}, 32'(bus.rf_we), 32'd0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        set_src(0, 5'd1, 32'h100);
        set_src(1, 5'd2, 32'h200);
        set_src(2, 5'd3, 32'h300);
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
        bus.rs1_addr  = 5'd7;
        bus.rs2_addr  = 5'd3;

        // Reset held with every source requesting.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_we",    32'(bus.rf_we),     32'd0);
        chk("rst_rs1",   32'(bus.rs1_busy),  32'd0);
        chk("rst_rs2",   32'(bus.rs2_busy),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all sources valid; each source posts fresh data after its transfer.
        for (int i = 0; i < 6; i++) begin
            cycle(3'(1 << (i % 3)), $sformatf("rr%0d", i));
            set_src(i % 3, 5'(i % 3 + 1), 32'(32'h1000 * (i + 1) + i % 3));
        end

        // Single source.
        bus.req_valid = 3'b010;
        set_src(1, 5'd5, 32'hDEADBEEF);
        cycle(3'b010, "single");
        bus.req_valid = 3'b000;
        cycle(3'b000, "single_idle");

        // Write to x0 is consumed without a write enable and still moves the pointer to 0.
        bus.req_valid = 3'b001;
        set_src(0, 5'd0, 32'h1234);
        cycle(3'b001, "x0");
        bus.req_valid = 3'b111;
        cycle(3'b010, "ptr_after_x0");
        bus.req_valid = 3'b000;

        // Scoreboard: reserve x7, commit it, then commit again with a same-edge re-reservation.
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd7;
        #1;
        chk("rs1_before_rsv", 32'(bus.rs1_busy), 32'd0);
        @(posedge clk);
        #1;
        bus.rsv_valid = 1'b0;
        chk("rs1_after_rsv", 32'(bus.rs1_busy), 32'd1);
        chk("rs2_clear",     32'(bus.rs2_busy), 32'd0);
        bus.req_valid = 3'b100;
        set_src(2, 5'd7, 32'hCAFE0007);
        cycle(3'b100, "wr_x7");
        chk("rs1_during_we", 32'(bus.rs1_busy), 32'd1);
        bus.req_valid = 3'b000;
        cycle(3'b000, "post_commit");
        chk("rs1_after_commit", 32'(bus.rs1_busy), 32'd0);

        bus.rsv_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rsv_valid = 1'b0;
        chk("rs1_rersv", 32'(bus.rs1_busy), 32'd1);
        bus.req_valid = 3'b100;
        set_src(2, 5'd7, 32'h0000BEEF);
        cycle(3'b100, "wr_x7b");
        bus.req_valid = 3'b000;
        bus.rsv_valid = 1'b1;
        cycle(3'b000, "commit_rsv");
        bus.rsv_valid = 1'b0;
        chk("rs1_set_wins", 32'(bus.rs1_busy), 32'd1);

        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd3;
        @(posedge clk);
        #1;
        bus.rsv_valid = 1'b0;
        chk("rs2_rsv", 32'(bus.rs2_busy), 32'd1);

        // Reset asserted while a write is on the port.
        bus.req_valid = 3'b001;
        set_src(0, 5'd9, 32'h9999);
        cycle(3'b001, "wr_x9");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",    32'(bus.rf_we),     32'd0);
        chk("mid_rst_waddr", 32'(bus.rf_waddr),  32'd0);
        chk("mid_rst_wdata", bus.rf_wdata,       32'd0);
        chk("mid_rst_rs1",   32'(bus.rs1_busy),  32'd0);
        chk("mid_rst_rs2",   32'(bus.rs2_busy),  32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 3'b111;
        cycle(3'b001, "post_rst");
        bus.req_valid = 3'b000;
        cycle(3'b000, "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
